// File: rtl/decode_inst_queue_pkg.sv
// rtl/decode_inst_queue_pkg.sv - shared widths and exception codes for the decode instruction queue
package decode_inst_queue_pkg;

    localparam int EXCCODE_W      = 5;
    localparam int PC_WIDTH_DEF   = 32;
    localparam int INST_WIDTH_DEF = 32;

    localparam logic [EXCCODE_W-1:0] EXC_INT  = 5'd0;
    localparam logic [EXCCODE_W-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXCCODE_W-1:0] EXC_ADES = 5'd5;
    localparam logic [EXCCODE_W-1:0] EXC_SYS  = 5'd8;
    localparam logic [EXCCODE_W-1:0] EXC_BP   = 5'd9;
    localparam logic [EXCCODE_W-1:0] EXC_RI   = 5'd10;

endpackage

// File: rtl/decode_inst_queue_tagfifo.sv
// rtl/decode_inst_queue_tagfifo.sv - in-order FIFO of queue entry indices awaiting memory data
module decode_inst_queue_tagfifo #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       push,
    input  logic [TAG_W-1:0]           push_tag,
    input  logic                       pop,
    output logic [TAG_W-1:0]           pop_tag,
    output logic [$clog2(ENTRIES):0]   count
);

    localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CW = $clog2(ENTRIES) + 1;

    logic [TAG_W-1:0] tags [ENTRIES];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Explicit wrap keeps the single-entry configuration correct.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) tags[wr_ptr] <= push_tag;
    end

    assign pop_tag = tags[rd_ptr];

endmodule

// File: rtl/decode_inst_queue.sv
// rtl/decode_inst_queue.sv - in-order fetch-to-decode instruction queue; same-cycle head bypass under DECODE_INST_QUEUE_BYPASS_EN
module decode_inst_queue
    import decode_inst_queue_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PC_WIDTH        = PC_WIDTH_DEF,
    parameter int INST_WIDTH      = INST_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    input  logic [PC_WIDTH-1:0]   req_pc,
    input  logic                  req_exc,
    input  logic [EXCCODE_W-1:0]  req_exccode,
    output logic                  req_ready,
    output logic                  mem_req,
    output logic [PC_WIDTH-1:0]   mem_addr,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic                  out_exc,
    output logic [EXCCODE_W-1:0]  out_exccode,
    input  logic                  out_ready,
    input  logic                  flush
);

    localparam int IW = $clog2(DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

    logic [IW-1:0]  head, tail;
    logic [IW:0]    occ;
    logic [OW-1:0]  live, stale;
    logic [OW:0]    inflight;
    logic [DEPTH-1:0] filled;

    logic [PC_WIDTH-1:0]   e_pc   [DEPTH];
    logic [INST_WIDTH-1:0] e_inst [DEPTH];
    logic                  e_exc  [DEPTH];
    logic [EXCCODE_W-1:0]  e_code [DEPTH];

    logic          can_alloc, alloc, drop, fill, pop, bypass_hit, stale_dec;
    logic [IW-1:0] fill_idx;

    assign inflight  = {1'b0, live} + {1'b0, stale};
    assign can_alloc = (occ < (IW+1)'(DEPTH)) && (inflight < (OW+1)'(MAX_OUTSTANDING));
    assign mem_req   = resetn && req_valid && can_alloc && !req_exc && !flush;
    assign req_ready = resetn && can_alloc && !flush && (req_exc || mem_addr_ok);
    assign mem_addr  = req_pc;
    assign alloc     = req_valid && req_ready;

    // Responses are in order: stale ones (issued before a flush) drain first.
    assign drop      = mem_data_ok && (stale != '0);
    assign fill      = mem_data_ok && (stale == '0) && (live != '0);
    assign stale_dec = mem_data_ok && ((stale != '0) || (live != '0));

    decode_inst_queue_tagfifo #(
        .ENTRIES (MAX_OUTSTANDING),
        .TAG_W   (IW)
    ) u_tagfifo (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (flush),
        .push     (alloc && !req_exc),
        .push_tag (tail),
        .pop      (fill),
        .pop_tag  (fill_idx),
        .count    (live)
    );

`ifdef DECODE_INST_QUEUE_BYPASS_EN
    assign bypass_hit = fill && (fill_idx == head);
`else
    assign bypass_hit = 1'b0;
`endif

    assign out_valid   = (filled[head] || bypass_hit) && !flush;
    assign out_pc      = e_pc[head];
    assign out_exc     = e_exc[head];
    assign out_exccode = e_code[head];
    assign out_inst    = bypass_hit ? mem_rdata : (e_exc[head] ? '0 : e_inst[head]);
    assign pop         = out_valid && out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head   <= '0;
            tail   <= '0;
            occ    <= '0;
            stale  <= '0;
            filled <= '0;
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            occ    <= '0;
            filled <= '0;
            stale  <= stale + live - OW'(stale_dec);
        end else begin
            if (alloc) begin
                filled[tail] <= req_exc;
                tail         <= tail + 1'b1;
            end
            if (fill) filled[fill_idx] <= 1'b1;
            // Applied last so a bypassed head is freed rather than marked filled.
            if (pop) begin
                filled[head] <= 1'b0;
                head         <= head + 1'b1;
            end
            occ <= occ + (IW+1)'(alloc) - (IW+1)'(pop);
            if (drop) stale <= stale - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            e_pc[tail]   <= req_pc;
            e_exc[tail]  <= req_exc;
            e_code[tail] <= req_exccode;
        end
        if (fill) e_inst[fill_idx] <= mem_rdata;
    end

endmodule

// File: tb/tb_decode_inst_queue.sv
// tb/tb_decode_inst_queue.sv - scoreboard bench for decode_inst_queue
module tb_decode_inst_queue;
    import decode_inst_queue_pkg::*;

`ifdef DECODE_INST_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 req_valid, req_exc, req_ready, mem_req, mem_addr_ok, mem_data_ok;
    logic [31:0]          req_pc, mem_addr, mem_rdata, out_pc, out_inst;
    logic [EXCCODE_W-1:0] req_exccode, out_exccode;
    logic                 out_valid, out_exc, out_ready, flush;

    decode_inst_queue #(.DEPTH(4), .MAX_OUTSTANDING(4), .PC_WIDTH(32), .INST_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_pc(req_pc), .req_exc(req_exc), .req_exccode(req_exccode),
        .req_ready(req_ready), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_exc(out_exc),
        .out_exccode(out_exccode), .out_ready(out_ready), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic                 exc;
        logic [EXCCODE_W-1:0] code;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] memq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic        g_acc, g_ov, g_rr, g_mr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h8BAD_0000;
    endfunction

    // One clock: drive at negedge, sample 2ns later, update memory model and scoreboard.
    task automatic step(input int rv, input logic [31:0] pc, input int ex, input int code,
                        input int aok, input int dok, input int ordy, input int fl);
        exp_t e;
        @(negedge clk);
        req_valid   = (rv != 0);
        req_pc      = pc;
        req_exc     = (ex != 0);
        req_exccode = EXCCODE_W'(code);
        mem_addr_ok = (aok != 0);
        mem_data_ok = (dok != 0);
        out_ready   = (ordy != 0);
        flush       = (fl != 0);
        mem_rdata   = (dok != 0 && memq.size() > 0) ? memq[0] : 32'hDEAD_BEEF;
        #2;
        assert (dok == 0 || memq.size() > 0) else $error("protocol: mem_data_ok with nothing in flight");
        g_acc = req_valid && req_ready;
        g_ov  = out_valid;
        g_rr  = req_ready;
        g_mr  = mem_req;
        if (fl != 0) check_val("ready_in_flush", 32'(req_ready), 32'd0);
        if (g_acc && ex == 0) begin
            check_val("mem_req", 32'(mem_req), 32'd1);
            check_val("mem_addr", mem_addr, pc);
        end
        if (out_valid && ordy != 0) begin
            if (sb.size() == 0) begin
                check_val("out_unexpected", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("out_pc", out_pc, e.pc);
                check_val("out_inst", out_inst, e.inst);
                check_val("out_exc", 32'(out_exc), 32'(e.exc));
                check_val("out_exccode", 32'(out_exccode), 32'(e.code));
                n_out++;
            end
        end
        if (dok != 0 && memq.size() > 0) void'(memq.pop_front());
        if (g_acc) begin
            if (ex == 0) memq.push_back(inst_of(pc));
            e.pc   = pc;
            e.inst = (ex != 0) ? 32'd0 : inst_of(pc);
            e.exc  = (ex != 0);
            e.code = EXCCODE_W'(code);
            sb.push_back(e);
        end
        if (fl != 0) sb.delete();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while ((sb.size() > 0 || memq.size() > 0) && k < 40) begin
            step(0, 32'h0, 0, 0, 0, (memq.size() > 0) ? 1 : 0, 1, 0);
            k++;
        end
        check_val(tag, 32'(sb.size() + memq.size()), 32'd0);
    endtask

    initial begin
        req_valid = 1'b1; req_pc = 32'h0; req_exc = 1'b0; req_exccode = '0;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b0; mem_rdata = '0;
        out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        req_valid = 1'b0;

        // Back-to-back fetch with responses on the following cycles.
        n_out = 0;
        step(1, 32'h1000, 0, 0, 1, 0, 1, 0);
        step(1, 32'h1004, 0, 0, 1, 1, 1, 0);
        check_val("resp_latency", 32'(g_ov), 32'(BYP));
        step(1, 32'h1008, 0, 0, 1, 1, 1, 0);
        check_val("resp_next_cycle", 32'(g_ov), 32'd1);
        step(1, 32'h100C, 0, 0, 1, 1, 1, 0);
        step(0, 32'h0, 0, 0, 0, 1, 1, 0);
        drain("t1_drain");
        check_val("t1_outputs", 32'(n_out), 32'd4);

        // Full queue back-pressure; one pop frees exactly one slot.
        n_out = 0;
        step(1, 32'h5000, 0, 0, 1, 0, 0, 0);
        step(1, 32'h5004, 0, 0, 1, 1, 0, 0);
        step(1, 32'h5008, 0, 0, 1, 1, 0, 0);
        step(1, 32'h500C, 0, 0, 1, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0, 1, 0, 0);
        step(1, 32'h5010, 0, 0, 1, 0, 0, 0);
        check_val("full_req_ready", 32'(g_rr), 32'd0);
        check_val("full_mem_req", 32'(g_mr), 32'd0);
        step(1, 32'h5010, 0, 0, 1, 0, 1, 0);
        check_val("full_pop_no_alloc", 32'(g_acc), 32'd0);
        step(1, 32'h5010, 0, 0, 1, 0, 0, 0);
        check_val("one_slot_accept", 32'(g_acc), 32'd1);
        step(1, 32'h5014, 0, 0, 1, 1, 0, 0);
        check_val("refill_refused", 32'(g_acc), 32'd0);
        drain("t2_drain");
        check_val("t2_outputs", 32'(n_out), 32'd5);

        // Flush with three requests in flight: their responses are dropped.
        n_out = 0;
        step(1, 32'h1800, 0, 0, 1, 0, 1, 0);
        step(1, 32'h1804, 0, 0, 1, 0, 1, 0);
        step(1, 32'h1808, 0, 0, 1, 0, 1, 0);
        step(1, 32'h180C, 0, 0, 1, 0, 1, 1);
        step(1, 32'h2000, 0, 0, 1, 0, 1, 0);
        check_val("post_flush_accept", 32'(g_acc), 32'd1);
        repeat (4) step(0, 32'h0, 0, 0, 0, 1, 1, 0);
        drain("t3_drain");
        check_val("t3_outputs", 32'(n_out), 32'd1);

        // Exception queued behind a pending fetch stays in program order.
        n_out = 0;
        step(1, 32'h3000, 0, 0, 1, 0, 1, 0);
        step(1, 32'h3004, 1, 4, 0, 0, 1, 0);
        step(0, 32'h0, 0, 0, 0, 1, 1, 0);
        drain("t4_drain");
        check_val("t4_outputs", 32'(n_out), 32'd2);
        step(1, 32'h3100, 1, 10, 0, 0, 0, 0);
        check_val("exc_same_cycle", 32'(g_ov), 32'd0);
        step(0, 32'h0, 0, 0, 0, 0, 1, 0);
        check_val("exc_next_cycle", 32'(g_ov), 32'd1);
        check_val("t4b_outputs", 32'(n_out), 32'd3);

        // Flush coinciding with a response while two are live leaves one stale.
        n_out = 0;
        step(1, 32'h4000, 0, 0, 1, 0, 1, 0);
        step(1, 32'h4004, 0, 0, 1, 0, 1, 0);
        step(0, 32'h0, 0, 0, 0, 1, 1, 1);
        step(1, 32'h4100, 0, 0, 1, 0, 1, 0);
        step(0, 32'h0, 0, 0, 0, 1, 1, 0);
        check_val("stale_drop", 32'(g_ov), 32'd0);
        step(0, 32'h0, 0, 0, 0, 1, 1, 0);
        check_val("live_fill_latency", 32'(g_ov), 32'(BYP));
        drain("t5_drain");
        check_val("t5_outputs", 32'(n_out), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
